// File: rtl/aes_job_arbiter_pkg.sv
// Shared types and sizing helpers for the AES job arbiter and its round-robin picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int BLK_W_DEF = 128;
    localparam int N_REQ_DEF = 4;

    // Index width for n requesters; at least one bit even for n == 1.
    function automatic int gid_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int GID_W = gid_w(N_REQ_DEF);

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Requester-side bus: per-requester block submit and one-hot result return.
// Latency: n/a (signal bundle).
// Backpressure: req_valid is held until req_ready; rsp_valid has no ready (always accepted).
// Ports: req_valid/req_pt/req_ready (submit), rsp_valid/rsp_ct/rsp_err (result).
interface aes_job_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int BLK_W = 128
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*BLK_W-1:0] req_pt;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [BLK_W-1:0]       rsp_ct;
    logic                   rsp_err;

    modport master (
        output req_valid, req_pt,
        input  req_ready, rsp_valid, rsp_ct, rsp_err
    );

    modport slave (
        input  req_valid, req_pt,
        output req_ready, rsp_valid, rsp_ct, rsp_err
    );
endinterface

// File: rtl/aes_job_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from ptr+1, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides whether to act on the grant.
// Ports: req (request vector), ptr (last winner), gnt (one-hot), idx (winner index).
module rr_arbiter
    import aes_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = gid_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // Offset 1..N from the pointer; offset N is the pointer itself, so the
        // previous winner is only picked again when nobody else is asking.
        for (int i = 1; i <= N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found                    = 1'b1;
                gnt[(int'(ptr) + i) % N] = 1'b1;
                idx                      = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one aes_encrypt core between N_REQ requesters, round-robin, one block in flight.
// Latency: accept T, core_load T+1, rsp_valid one cycle after the core's first valid in WAIT.
// Backpressure: req_ready only in IDLE; a new job is refused until the previous response is out.
// Ports: clk, rst_n (async active-low), req_bus (requester interface, slave side),
//        core_load/core_pt/core_ct/core_valid (encrypt core), busy, grant_id.
// Optional: AES_ARB_TIMEOUT_EN adds a WAIT-state watchdog that returns rsp_err=1, rsp_ct=0.
module aes_job_arbiter
    import aes_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int BLK_W       = BLK_W_DEF,
    parameter int TIMEOUT_CYC = 64,
    localparam int GW         = gid_w(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_job_arbiter_if.slave     req_bus,
    output logic                 core_load,
    output logic [BLK_W-1:0]     core_pt,
    input  logic [BLK_W-1:0]     core_ct,
    input  logic                 core_valid,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    arb_state_t       state, state_nxt;
    logic [GW-1:0]    rr_ptr;
    logic [N_REQ-1:0] pick_gnt;
    logic [GW-1:0]    pick_idx;
    logic [BLK_W-1:0] pt_reg;
    logic             accept;
    logic             capture;
    logic             timeout;

    rr_arbiter #(.N(N_REQ), .IDX_W(GW)) u_rr (
        .req (req_bus.req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        accept            = 1'b0;
        capture           = 1'b0;
        core_load         = 1'b0;
        req_bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (|req_bus.req_valid) begin
                    accept            = 1'b1;
                    req_bus.req_ready = pick_gnt;
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                core_load = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (core_valid) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    // pt_reg only changes on accept, so the core sees a stable block for the whole job.
    assign core_pt = pt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_reg            <= '0;
            grant_id          <= '0;
            rr_ptr            <= GW'(N_REQ - 1);
            req_bus.rsp_valid <= '0;
            req_bus.rsp_ct    <= '0;
        end else begin
            req_bus.rsp_valid <= '0;
            if (accept) begin
                pt_reg   <= req_bus.req_pt[pick_idx*BLK_W +: BLK_W];
                grant_id <= pick_idx;
            end
            if (capture)      req_bus.rsp_ct <= core_ct;
            else if (timeout) req_bus.rsp_ct <= '0;
            if (state == WAIT && state_nxt == RESP)
                req_bus.rsp_valid <= N_REQ'(1) << grant_id;
            // Pointer moves only when a job completes, so an abandoned job
            // does not cost its requester a turn.
            if (state == RESP)
                rr_ptr <= grant_id;
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            err_q;

    // Zero on the first WAIT cycle, so the watchdog fires TIMEOUT_CYC cycles after WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             wait_cnt <= '0;
        else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
        else                    wait_cnt <= '0;
    end

    assign timeout = (state == WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      err_q <= 1'b0;
        else if (accept)                 err_q <= 1'b0;
        else if (timeout && !core_valid) err_q <= 1'b1;
    end

    assign req_bus.rsp_err = err_q;
`else
    assign timeout         = 1'b0;
    assign req_bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_job_arbiter.sv
module tb_aes_job_arbiter;

    localparam int N  = 4;
    localparam int W  = 128;
    localparam int TO = 16;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         core_load;
    logic [W-1:0] core_pt;
    logic [W-1:0] core_ct = '0;
    logic         core_valid;
    logic         busy;
    logic [1:0]   grant_id;

    aes_job_arbiter_if #(.N_REQ(N), .BLK_W(W)) bus ();

    aes_job_arbiter #(.N_REQ(N), .BLK_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_bus    (bus),
        .core_load  (core_load),
        .core_pt    (core_pt),
        .core_ct    (core_ct),
        .core_valid (core_valid),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    // Core stand-in keyed with 000102..0f: knows the FIPS-197 vector, otherwise a fixed scramble.
    function automatic logic [127:0] model_ct(input logic [127:0] p);
        if (p == FIPS_PT) return FIPS_CT;
        return {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
    endfunction

    int           core_lat = 1;
    bit           core_en  = 1'b1;
    bit           spur     = 1'b0;
    bit           pending  = 1'b0;
    int           cnt      = 0;
    logic [127:0] pt_l     = '0;
    logic         model_vld = 1'b0;

    assign core_valid = model_vld | spur;

    // Driven on the falling edge so the arbiter samples it cleanly at the next rising edge.
    always @(negedge clk) begin
        model_vld = 1'b0;
        if (!rst_n) begin
            pending = 1'b0;
        end else if (pending) begin
            if (cnt <= 1) begin
                model_vld = core_en;
                core_ct   = model_ct(pt_l);
                pending   = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
        if (rst_n && core_load) begin
            pending = 1'b1;
            cnt     = core_lat;
            pt_l    = core_pt;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pt_of(input logic [127:0] base, input int i);
        return base ^ {8'(i), 120'h0};
    endfunction

    task automatic drive_pts(input logic [127:0] base);
        for (int i = 0; i < N; i++) bus.req_pt[i*W +: W] = pt_of(base, i);
    endtask

    typedef struct {
        logic [3:0]   mask;
        logic [1:0]   exp_g;
        int           lat;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs[15];

    // One full job from IDLE: accept, issue, wait, response, back to IDLE.
    task automatic run_job(input vec_t v, output logic [127:0] ct_out);
        logic [127:0] ptg;
        logic [3:0]   oh;
        int           n;
        int           loads;
        int           rdy_extra;
        oh       = 4'b0001 << v.exp_g;
        ptg      = pt_of(v.pt, int'(v.exp_g));
        core_lat = v.lat;
        drive_pts(v.pt);
        bus.req_valid = v.mask;
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("req_ready", bus.req_ready, oh);
        tick();
        chk("grant_id", grant_id, v.exp_g);
        chk("issue_busy", busy, 1'b1);
        chk("issue_load", core_load, 1'b1);
        chk("issue_pt", core_pt, ptg);
        chk("err_clear", bus.rsp_err, 1'b0);
        loads     = 1;
        rdy_extra = 0;
        n         = 0;
        while (bus.rsp_valid == '0 && n < v.lat + 20) begin
            tick();
            n++;
            if (core_load) loads++;
            if (bus.req_ready != '0) rdy_extra++;
        end
        chk("latency", n, v.lat + 1);
        chk("load_pulses", loads, 1);
        chk("ready_outside_idle", rdy_extra, 0);
        chk("rsp_valid", bus.rsp_valid, oh);
        chk("rsp_ct", bus.rsp_ct, model_ct(ptg));
        chk("rsp_err", bus.rsp_err, 1'b0);
        chk("resp_busy", busy, 1'b1);
        ct_out = bus.rsp_ct;
        bus.req_valid = '0;
        tick();
        chk("rsp_one_cycle", bus.rsp_valid, 4'b0000);
        chk("back_idle", busy, 1'b0);
        chk("rsp_ct_hold", bus.rsp_ct, model_ct(ptg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [127:0] ct;
        int           n;
        int           stray;

        bus.req_valid = '0;
        bus.req_pt    = '0;

        // Fairness from reset, then sparse masks exercising wrap-around.
        vecs[0]  = '{4'b1111, 2'd0, 2, 128'h0102030405060708090a0b0c0d0e0f10};
        vecs[1]  = '{4'b1111, 2'd1, 1, 128'hdeadbeef00000000cafef00d12345678};
        vecs[2]  = '{4'b1111, 2'd2, 3, 128'h11111111222222223333333344444444};
        vecs[3]  = '{4'b1111, 2'd3, 4, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f};
        vecs[4]  = '{4'b1111, 2'd0, 1, 128'h0000000000000000000000000000abcd};
        vecs[5]  = '{4'b1111, 2'd1, 2, 128'h55aa55aa55aa55aa55aa55aa55aa55aa};
        vecs[6]  = '{4'b1111, 2'd2, 5, 128'h0123456789abcdeffedcba9876543210};
        vecs[7]  = '{4'b1111, 2'd3, 2, 128'h13579bdf02468ace13579bdf02468ace};
        vecs[8]  = '{4'b0001, 2'd0, 3, FIPS_PT};
        vecs[9]  = '{4'b0100, 2'd2, 2, 128'h00ff00ff00ff00ff00ff00ff00ff00ff};
        vecs[10] = '{4'b0011, 2'd0, 1, 128'h7777777788888888999999990000aaaa};
        vecs[11] = '{4'b0011, 2'd1, 2, 128'hababababcdcdcdcdefefefef01010101};
        vecs[12] = '{4'b1000, 2'd3, 3, 128'h0f0f0f0ff0f0f0f00f0f0f0ff0f0f0f0};
        vecs[13] = '{4'b1001, 2'd0, 1, 128'h24681357246813572468135724681357};
        vecs[14] = '{4'b0110, 2'd1, 2, 128'hc0ffee00c0ffee00c0ffee00c0ffee00};

        // Reset values.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 2'd0);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("rst_rsp_ct", bus.rsp_ct, 128'h0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_core_load", core_load, 1'b0);
        chk("rst_core_pt", core_pt, 128'h0);
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 15; k++) begin
            run_job(vecs[k], ct);
            if (k == 8) chk("fips_ct", ct, FIPS_CT);
        end

        // Spurious core_valid in IDLE: nothing happens.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_idle_busy", busy, 1'b0);
        chk("spur_idle_rsp", bus.rsp_valid, 4'b0000);
        tick();
        chk("spur_idle_rsp2", bus.rsp_valid, 4'b0000);
        chk("spur_idle_load", core_load, 1'b0);

        // Spurious core_valid in ISSUE: ignored, real result still delivered.
        core_lat = 4;
        drive_pts(128'h9999aaaabbbbccccddddeeeeffff0000);
        bus.req_valid = 4'b0100;
        #1;
        chk("spur_req_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        spur = 1'b1;
        chk("spur_issue_load", core_load, 1'b1);
        tick();
        spur = 1'b0;
        chk("spur_wait_busy", busy, 1'b1);
        chk("spur_wait_rsp", bus.rsp_valid, 4'b0000);
        n = 1;
        while (bus.rsp_valid == '0 && n < 30) begin
            tick();
            n++;
        end
        chk("spur_latency", n, 5);
        chk("spur_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("spur_rsp_ct", bus.rsp_ct, model_ct(pt_of(128'h9999aaaabbbbccccddddeeeeffff0000, 2)));
        tick();

        // Reset in the middle of WAIT: job abandoned, pointer back to N-1.
        core_lat = 10;
        drive_pts(128'h1234000000000000000000000000abcd);
        bus.req_valid = 4'b1000;
        #1;
        chk("mid_req_ready", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        chk("mid_wait_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_grant", grant_id, 2'd0);
        chk("mid_rst_load", core_load, 1'b0);
        chk("mid_rst_pt", core_pt, 128'h0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("mid_rst_rsp_ct", bus.rsp_ct, 128'h0);
        chk("mid_rst_rsp_err", bus.rsp_err, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.rsp_valid != '0 || busy) stray++;
        end
        chk("mid_no_response", stray, 0);
        run_job('{4'b1111, 2'd0, 2, 128'h0badc0de0badc0de0badc0de0badc0de}, ct);

`ifdef AES_ARB_TIMEOUT_EN
        // Core never answers: watchdog response 16 cycles after WAIT entry.
        core_en  = 1'b0;
        core_lat = 2;
        drive_pts(128'h77770000777700007777000077770000);
        bus.req_valid = 4'b0010;
        #1;
        chk("to_req_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        tick();
        n = 0;
        while (bus.rsp_valid == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("to_rsp_err", bus.rsp_err, 1'b1);
        chk("to_rsp_ct", bus.rsp_ct, 128'h0);
        tick();
        chk("to_err_held", bus.rsp_err, 1'b1);
        core_en = 1'b1;
        run_job('{4'b0001, 2'd0, 2, 128'h31415926535897932384626433832795}, ct);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
